// File: rtl/batch_dispatch_arbiter.sv
// Batch dispatch arbiter: holds one transaction, offers it to NUM_BATCHES filter
// engines in round-robin order, retries on conflict/timeout and reports the verdict.
module batch_dispatch_arbiter #(
   parameter  int unsigned ID_W        = 64,
   parameter  int unsigned DEP_W       = 64,
   parameter  int unsigned MAX_DEPS    = 1024,
   parameter  int unsigned NUM_BATCHES = 4,
   parameter  int unsigned TIMEOUT     = 255,
   localparam int unsigned BID_W       = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1,
   localparam int unsigned TMR_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1,
   localparam int unsigned SET_W       = DEP_W * MAX_DEPS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ID_W-1:0]        in_id,
   input  logic [SET_W-1:0]       in_rd_deps,
   input  logic [SET_W-1:0]       in_wr_deps,
   output logic [NUM_BATCHES-1:0] fe_valid,
   input  logic [NUM_BATCHES-1:0] fe_ready,
   output logic [ID_W-1:0]        fe_id,
   output logic [SET_W-1:0]       fe_rd_deps,
   output logic [SET_W-1:0]       fe_wr_deps,
   input  logic [NUM_BATCHES-1:0] fe_resp_valid,
   input  logic [NUM_BATCHES-1:0] fe_resp_conflict,
   output logic                   out_valid,
   output logic                   out_accepted,
   output logic [BID_W-1:0]       out_batch,
   output logic [ID_W-1:0]        out_id,
   output logic                   out_timeout,
   output logic                   busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic [BID_W-1:0] LAST_BID = BID_W'(NUM_BATCHES - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t           state;
   logic [BID_W-1:0] cur;
   logic [BID_W-1:0] rr_ptr;
   logic [BID_W-1:0] tries;
   logic [TMR_W-1:0] timer;
   logic             tmo_flag;
   logic             expired;
   logic             hs;
   logic             resp;
   logic             resp_conflict;
   logic             last_try;
   logic             retry;
   logic             retry_tmo;

   function automatic logic [BID_W-1:0] next_bid(input logic [BID_W-1:0] b);
      return (b == LAST_BID) ? '0 : b + 1'b1;
   endfunction

   function automatic logic [NUM_BATCHES-1:0] lane_sel(input logic [BID_W-1:0] b);
      return NUM_BATCHES'(1) << b;
   endfunction

   always_comb begin
      expired       = (TIMEOUT != 0) && (timer == TMR_LAST);
      hs            = fe_ready[cur];
      resp          = fe_resp_valid[cur];
      resp_conflict = fe_resp_conflict[cur];
      last_try      = (tries == LAST_BID);
      retry         = 1'b0;
      retry_tmo     = 1'b0;
      case (state)
         S_ISSUE: begin
            retry     = !hs && expired;
            retry_tmo = retry;
         end
         S_WAIT: begin
            retry     = resp ? resp_conflict : expired;
            retry_tmo = !resp && expired;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cur          <= '0;
         rr_ptr       <= '0;
         tries        <= '0;
         timer        <= '0;
         tmo_flag     <= 1'b0;
         in_ready     <= 1'b0;
         busy         <= 1'b0;
         fe_valid     <= '0;
         fe_id        <= '0;
         fe_rd_deps   <= '0;
         fe_wr_deps   <= '0;
         out_valid    <= 1'b0;
         out_accepted <= 1'b0;
         out_batch    <= '0;
         out_id       <= '0;
         out_timeout  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         timer     <= timer + 1'b1;
         case (state)
            S_IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  fe_id      <= in_id;
                  fe_rd_deps <= in_rd_deps;
                  fe_wr_deps <= in_wr_deps;
                  cur        <= rr_ptr;
                  tries      <= '0;
                  tmo_flag   <= 1'b0;
                  timer      <= '0;
                  fe_valid   <= lane_sel(rr_ptr);
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (hs) begin
                  fe_valid <= '0;
                  timer    <= '0;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (resp && !resp_conflict) begin
                  out_valid    <= 1'b1;
                  out_accepted <= 1'b1;
                  out_batch    <= cur;
                  out_id       <= fe_id;
                  out_timeout  <= tmo_flag;
                  rr_ptr       <= next_bid(cur);
                  state        <= S_DONE;
               end
            end
            S_DONE: begin
               busy     <= 1'b0;
               in_ready <= 1'b1;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         // Conflict or expiry overrides the per-state update: next batch or final reject.
         if (retry) begin
            timer <= '0;
            if (retry_tmo) tmo_flag <= 1'b1;
            if (last_try) begin
               fe_valid     <= '0;
               out_valid    <= 1'b1;
               out_accepted <= 1'b0;
               out_batch    <= '0;
               out_id       <= fe_id;
               out_timeout  <= tmo_flag | retry_tmo;
               state        <= S_DONE;
            end else begin
               tries    <= tries + 1'b1;
               cur      <= next_bid(cur);
               fe_valid <= lane_sel(next_bid(cur));
               state    <= S_ISSUE;
            end
         end
      end
   end

endmodule

// File: tb/tb_batch_dispatch_arbiter.sv
// Randomized bench for batch_dispatch_arbiter: scripted per-lane engine behaviour
// checked against an attempt-level model of offers, verdict, rr pointer and latency.
module tb_batch_dispatch_arbiter;

   localparam int unsigned ID_W   = 16;
   localparam int unsigned DEP_W  = 8;
   localparam int unsigned MAXD   = 4;
   localparam int unsigned NB     = 4;
   localparam int unsigned TMO    = 8;
   localparam int unsigned BID_W  = 2;
   localparam int unsigned SET_W  = DEP_W * MAXD;
   localparam int unsigned BUDGET = 200;

   localparam int unsigned M_ACC = 0;  // ready after dr, clean verdict after ds
   localparam int unsigned M_CON = 1;  // ready after dr, conflict verdict after ds
   localparam int unsigned M_SIL = 2;  // never ready
   localparam int unsigned M_NOR = 3;  // ready after dr, never answers

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [ID_W-1:0]  in_id = '0;
   logic [SET_W-1:0] in_rd_deps = '0;
   logic [SET_W-1:0] in_wr_deps = '0;
   logic [NB-1:0]    fe_valid;
   logic [NB-1:0]    fe_ready = '0;
   logic [ID_W-1:0]  fe_id;
   logic [SET_W-1:0] fe_rd_deps;
   logic [SET_W-1:0] fe_wr_deps;
   logic [NB-1:0]    fe_resp_valid = '0;
   logic [NB-1:0]    fe_resp_conflict = '0;
   logic             out_valid;
   logic             out_accepted;
   logic [BID_W-1:0] out_batch;
   logic [ID_W-1:0]  out_id;
   logic             out_timeout;
   logic             busy;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned m_rr = 0;
   int unsigned mode [NB];
   int unsigned dr [NB];
   int unsigned ds [NB];

   batch_dispatch_arbiter #(
      .ID_W(ID_W), .DEP_W(DEP_W), .MAX_DEPS(MAXD), .NUM_BATCHES(NB), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
      .in_rd_deps(in_rd_deps), .in_wr_deps(in_wr_deps), .fe_valid(fe_valid),
      .fe_ready(fe_ready), .fe_id(fe_id), .fe_rd_deps(fe_rd_deps), .fe_wr_deps(fe_wr_deps),
      .fe_resp_valid(fe_resp_valid), .fe_resp_conflict(fe_resp_conflict),
      .out_valid(out_valid), .out_accepted(out_accepted), .out_batch(out_batch),
      .out_id(out_id), .out_timeout(out_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic set_lane(input int unsigned l, input int unsigned m,
                           input int unsigned r, input int unsigned s);
      mode[l] = m;
      dr[l]   = r;
      ds[l]   = s;
   endtask

   task automatic set_all(input int unsigned m);
      for (int unsigned l = 0; l < NB; l++) set_lane(l, m, 0, 0);
   endtask

   // One transaction end to end; engines follow mode/dr/ds, model predicts the outcome.
   task automatic run_tx(input logic [ID_W-1:0] id, input bit stray, input string name);
      logic [SET_W-1:0] rd, wr;
      logic [NB-1:0]    prev_fv;
      int unsigned exp_sig, got_sig, exp_lat, got_lat, exp_batch, lane, sl;
      int unsigned rcnt, wcnt, ctl_bad, pay_bad, oh_bad, wt;
      bit exp_acc, exp_tmo, done, waiting;

      exp_sig = 0; exp_lat = 1; exp_acc = 0; exp_tmo = 0; exp_batch = 0;
      for (int unsigned k = 0; k < NB && !exp_acc; k++) begin
         lane    = (m_rr + k) % NB;
         exp_sig = (exp_sig << 4) | (lane + 1);
         if (mode[lane] == M_ACC) begin
            exp_lat  += dr[lane] + ds[lane] + 2;
            exp_acc   = 1;
            exp_batch = lane;
         end else if (mode[lane] == M_CON) begin
            exp_lat += dr[lane] + ds[lane] + 2;
         end else if (mode[lane] == M_SIL) begin
            exp_lat += TMO;
            exp_tmo  = 1;
         end else begin
            exp_lat += dr[lane] + 1 + TMO;
            exp_tmo  = 1;
         end
      end
      if (exp_acc) m_rr = (exp_batch + 1) % NB;

      wt = 0;
      while (in_ready !== 1'b1 && wt < 20) begin
         @(negedge clk);
         wt++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s.in_ready_wait got %b want 1", name, in_ready);
         return;
      end

      rd = SET_W'($urandom);
      wr = SET_W'($urandom);
      in_valid = 1'b1; in_id = id; in_rd_deps = rd; in_wr_deps = wr;
      @(posedge clk);
      got_sig = 0; got_lat = 0; done = 0; waiting = 0; prev_fv = '0;
      lane = 0; rcnt = 0; wcnt = 0; ctl_bad = 0; pay_bad = 0; oh_bad = 0;
      for (int unsigned cyc = 1; cyc <= BUDGET && !done; cyc++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_id = ID_W'($urandom); in_rd_deps = SET_W'($urandom); in_wr_deps = SET_W'($urandom);
         fe_ready = '0; fe_resp_valid = '0; fe_resp_conflict = '0;
         if ($countones(fe_valid) > 1) oh_bad++;
         if (out_valid === 1'b1) begin
            done = 1;
            got_lat = cyc;
         end else begin
            if (in_ready !== 1'b0 || busy !== 1'b1) ctl_bad++;
            if (fe_valid != '0) begin
               for (int unsigned i = 0; i < NB; i++) if (fe_valid[i]) lane = i;
               if (fe_valid != prev_fv) begin
                  got_sig = (got_sig << 4) | (lane + 1);
                  rcnt = 0;
                  waiting = 0;
               end
               if (fe_id !== id || fe_rd_deps !== rd || fe_wr_deps !== wr) pay_bad++;
               sl = (lane + 2) % NB;
               if (stray) fe_ready[sl] = 1'b1;
               if (mode[lane] != M_SIL && rcnt == dr[lane]) begin
                  fe_ready[lane] = 1'b1;
                  waiting = 1;
                  wcnt = 0;
               end
               rcnt++;
            end else if (waiting) begin
               sl = (lane == 0) ? 1 : 0;
               if ((mode[lane] == M_ACC || mode[lane] == M_CON) && wcnt == ds[lane]) begin
                  fe_resp_valid[lane]    = 1'b1;
                  fe_resp_conflict[lane] = (mode[lane] == M_CON);
                  waiting = 0;
               end else if (stray) begin
                  fe_resp_valid[sl] = 1'b1;
               end
               wcnt++;
            end
            prev_fv = fe_valid;
         end
      end
      fe_ready = '0; fe_resp_valid = '0; fe_resp_conflict = '0;

      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s.out_valid_budget got none within %0d cycles want a result", name, BUDGET);
         return;
      end
      n_checks++;
      if (got_sig !== exp_sig) begin
         n_fail++;
         $display("FAIL %s.offer_order got %h want %h (lane+1 per nibble)", name, got_sig, exp_sig);
      end
      n_checks++;
      if (out_accepted !== exp_acc) begin
         n_fail++;
         $display("FAIL %s.accepted got %b want %b", name, out_accepted, exp_acc);
      end
      n_checks++;
      if (out_batch !== BID_W'(exp_batch)) begin
         n_fail++;
         $display("FAIL %s.batch got %0d want %0d", name, out_batch, exp_batch);
      end
      n_checks++;
      if (out_id !== id) begin
         n_fail++;
         $display("FAIL %s.out_id got %h want %h", name, out_id, id);
      end
      n_checks++;
      if (out_timeout !== exp_tmo) begin
         n_fail++;
         $display("FAIL %s.timeout_flag got %b want %b", name, out_timeout, exp_tmo);
      end
      n_checks++;
      if (got_lat !== exp_lat) begin
         n_fail++;
         $display("FAIL %s.latency got %0d want %0d", name, got_lat, exp_lat);
      end
      n_checks++;
      if (ctl_bad !== 0) begin
         n_fail++;
         $display("FAIL %s.in_ready_busy got %0d bad cycles want 0", name, ctl_bad);
      end
      n_checks++;
      if (pay_bad !== 0) begin
         n_fail++;
         $display("FAIL %s.payload_stable got %0d bad cycles want 0", name, pay_bad);
      end
      n_checks++;
      if (oh_bad !== 0) begin
         n_fail++;
         $display("FAIL %s.fe_valid_onehot got %0d bad cycles want 0", name, oh_bad);
      end

      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s.out_valid_pulse got %b want 0", name, out_valid);
      end
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s.idle_after got in_ready=%b busy=%b want 1 0", name, in_ready, busy);
      end
      n_checks++;
      if (out_id !== id) begin
         n_fail++;
         $display("FAIL %s.out_id_hold got %h want %h", name, out_id, id);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({in_ready, busy, out_valid, out_accepted, out_timeout} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset.ctl got %b want 00000", {in_ready, busy, out_valid, out_accepted, out_timeout});
      end
      n_checks++;
      if (fe_valid !== '0 || out_batch !== '0) begin
         n_fail++;
         $display("FAIL reset.fe_valid_batch got %b %0d want 0 0", fe_valid, out_batch);
      end
      n_checks++;
      if (fe_id !== '0 || out_id !== '0 || fe_rd_deps !== '0 || fe_wr_deps !== '0) begin
         n_fail++;
         $display("FAIL reset.held got fe_id=%h out_id=%h want 0", fe_id, out_id);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset.release got in_ready=%b busy=%b want 1 0", in_ready, busy);
      end
      m_rr = 0;
   endtask

   task automatic test_basic();
      set_all(M_ACC);
      run_tx(16'h0011, 1'b0, "basic");
   endtask

   task automatic test_rr_conflict();
      set_all(M_ACC);
      set_lane(1, M_CON, 1, 2);
      set_lane(2, M_CON, 0, 3);
      set_lane(3, M_ACC, 2, 2);
      run_tx(16'h0222, 1'b1, "rr_conflict");
   endtask

   task automatic test_all_conflict();
      for (int unsigned l = 0; l < NB; l++) set_lane(l, M_CON, l % 2, (l + 1) % 3);
      run_tx(16'h0333, 1'b0, "all_conflict");
   endtask

   task automatic test_timeout();
      set_all(M_ACC);
      set_lane(m_rr, M_NOR, 0, 0);
      run_tx(16'h0444, 1'b0, "timeout");
      set_all(M_SIL);
      set_lane((m_rr + 3) % NB, M_CON, 0, 0);
      run_tx(16'h0445, 1'b0, "timeout_reject");
   endtask

   task automatic test_backpressure();
      set_all(M_ACC);
      set_lane(m_rr, M_ACC, 3, 0);
      run_tx(16'h0555, 1'b0, "backpressure");
   endtask

   task automatic test_reset_mid();
      int unsigned bad, wt;
      wt = 0;
      while (in_ready !== 1'b1 && wt < 20) begin
         @(negedge clk);
         wt++;
      end
      in_valid = 1'b1; in_id = 16'h5A5A;
      in_rd_deps = SET_W'($urandom); in_wr_deps = SET_W'($urandom);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      fe_ready = fe_valid;
      @(negedge clk);
      fe_ready = '0;
      n_checks++;
      if (busy !== 1'b1 || fe_valid !== '0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid.in_wait got busy=%b fe_valid=%b want 1 0", busy, fe_valid);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, busy, out_valid, out_accepted, out_timeout, fe_valid, out_batch} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid.ctl got %b want 0", {in_ready, busy, out_valid, fe_valid});
      end
      n_checks++;
      if (fe_id !== '0 || out_id !== '0 || fe_rd_deps !== '0 || fe_wr_deps !== '0) begin
         n_fail++;
         $display("FAIL reset_mid.held got fe_id=%h out_id=%h want 0", fe_id, out_id);
      end
      bad = 0;
      repeat (2) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid.release got in_ready=%b want 1", in_ready);
      end
      repeat (3) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL reset_mid.no_out_valid got %0d pulses want 0", bad);
      end
      m_rr = 0;
      set_all(M_ACC);
      run_tx(16'h0666, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      int unsigned r;
      for (int n = 0; n < 30; n++) begin
         for (int unsigned l = 0; l < NB; l++) begin
            r = $urandom_range(0, 9);
            set_lane(l, (r < 4) ? M_ACC : (r < 7) ? M_CON : (r < 8) ? M_SIL : M_NOR,
                     $urandom_range(0, 4), $urandom_range(0, 4));
         end
         run_tx(ID_W'($urandom), 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rr_conflict();
      test_all_conflict();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
